// File: rtl/bram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_pkg : shared constants and FSM state type for bram_stream_reader |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package bram_pkg;

  localparam int c_ADDR_WIDTH = 11;
  localparam int c_DATA_WIDTH = 192;
  localparam int c_DEPTH      = 2048;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/stream_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_fifo2 : two-entry valid/ready FIFO with synchronous reset      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             w_push;
  logic             w_pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_stream_reader : bursts BRAM words out as a valid/ready stream    |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = c_ADDR_WIDTH,
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int DEPTH      = c_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;

  logic                  w_pop;
  logic                  w_fifo_in_ready;
  logic [1:0]            w_occ;
  logic                  w_credit_ok;
  logic                  w_final_read;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic [DATA_WIDTH:0]   w_fifo_out;

  assign w_pop        = out_valid && out_ready;
  assign w_issue_addr = ADDR_WIDTH'(({1'b0, base_q} + issued_q) % (ADDR_WIDTH+1)'(DEPTH));
  assign w_final_read = (issued_q == len_q - (ADDR_WIDTH+1)'(1));
  assign w_occ        = out_valid ? (w_fifo_in_ready ? 2'd1 : 2'd2) : 2'd0;
  // Count the word leaving this cycle as already gone so a full pipe still issues every cycle.
  assign w_credit_ok  = ({1'b0, w_occ} + {2'b0, rd_valid_q}) < (3'd2 + {2'b0, w_pop});

  assign busy    = (state_q != ST_IDLE);
  assign rd_addr = re ? w_issue_addr : last_addr_q;

  always_comb begin
    state_d = state_q;
    re      = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (length == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (w_credit_ok) begin
          re = 1'b1;
          if (w_final_read) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (w_pop && out_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      last_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= re;
      rd_last_q  <= re && w_final_read;
      if (state_q == ST_IDLE && start) begin
        base_q   <= base_addr;
        len_q    <= length;
        issued_q <= '0;
      end else if (re) begin
        issued_q    <= issued_q + (ADDR_WIDTH+1)'(1);
        last_addr_q <= w_issue_addr;
      end
    end
  end

  // The last-word tag travels with the data so out_last needs no counter on the output side.
  stream_fifo2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (rd_valid_q),
    .in_ready_o  (w_fifo_in_ready),
    .in_data_i   ({rd_last_q, rd_data}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (w_fifo_out)
  );

  assign out_last = w_fifo_out[DATA_WIDTH];
  assign out_data = w_fifo_out[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bram_stream_reader : model-checked bench for bram_stream_reader    |
// | Revision              : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_bram_stream_reader;

  localparam int AW    = 11;
  localparam int DW    = 192;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, re;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;

  logic [DW-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;
  int ready_pct  = 100;
  int st_cyc   = 0;

  // logs filled by the monitor
  int            acc_cyc[$];
  logic [DW-1:0] acc_data[$];
  logic          acc_last[$];
  int            re_log[$];
  int            done_cnt = 0;
  int            done_cyc = -1;

  // reference model state
  bit            m_busy = 0, m_done = 0, m_after_rst = 0, prev_stall = 0;
  int            m_base = 0, m_len = 0, m_issued = 0, m_accepted = 0, m_last_addr = 0;
  logic [DW:0]   m_q[$];
  logic [DW:0]   prev_word = '0;

  bram_stream_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .re        (re),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (re) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a burst is the list mem[(base+i) mod DEPTH], delivered in order,
  // at most two words requested-but-not-taken, done the cycle after the last handshake.
  always @(negedge clk) begin : mon
    bit acc, nxt_done;
    logic [DW:0] w;
    if (rst) begin
      m_busy = 0; m_done = 0; m_q.delete();
      m_issued = 0; m_accepted = 0; m_len = 0; m_last_addr = 0;
      prev_stall = 0; m_after_rst = 1;
    end else begin
      if (m_after_rst) begin
        chki("rst_busy", int'(busy), 0);
        chki("rst_done", int'(done), 0);
        chki("rst_re", int'(re), 0);
        chki("rst_rd_addr", int'(rd_addr), 0);
        chki("rst_out_valid", int'(out_valid), 0);
        chki("rst_out_last", int'(out_last), 0);
        chk("rst_out_data", {1'b0, out_data}, '0);
        m_after_rst = 0;
      end
      chki("busy", int'(busy), int'(m_busy));
      chki("done", int'(done), int'(m_done));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (re) begin
        chki("re_allowed", int'(m_busy && !m_done && m_issued < m_len), 1);
        chki("rd_addr", int'(rd_addr), (m_base + m_issued) % DEPTH);
        re_log.push_back(int'(rd_addr));
        m_last_addr = int'(rd_addr);
        m_issued++;
      end else begin
        chki("rd_addr_hold", int'(rd_addr), m_last_addr);
      end
      if (prev_stall) begin
        chki("stall_valid", int'(out_valid), 1);
        chk("stall_word", {out_last, out_data}, prev_word);
      end
      acc = 0;
      if (out_valid) begin
        chki("valid_has_word", int'(m_q.size() != 0), 1);
        if (out_ready && m_q.size() != 0) begin
          w = m_q.pop_front();
          chk("stream_word", {out_last, out_data}, w);
          m_accepted++;
          acc = 1;
          acc_cyc.push_back(cyc);
          acc_data.push_back(out_data);
          acc_last.push_back(out_last);
        end
      end
      chki("outstanding_le2", int'((m_issued - m_accepted) <= 2), 1);
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};

      nxt_done = acc && (m_accepted == m_len);
      if (!m_busy && start) begin
        m_busy = 1;
        m_base = int'(base_addr);
        m_len  = int'(length);
        m_issued = 0;
        m_accepted = 0;
        m_q.delete();
        for (int i = 0; i < m_len; i++)
          m_q.push_back({(i == m_len - 1), mem[(m_base + i) % DEPTH]});
        if (m_len == 0) nxt_done = 1;
      end else if (m_done) begin
        m_busy = 0;
      end
      m_done = nxt_done;
    end
  end

  // out_ready driver: 0 = held high, 1 = toggling, 2 = random with ready_pct
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(99) < ready_pct);
      endcase
    end
  end

  task automatic clear_logs();
    acc_cyc.delete(); acc_data.delete(); acc_last.delete(); re_log.delete();
    done_cnt = 0; done_cyc = -1;
  endtask

  task automatic do_start(input int b, input int l);
    base_addr = AW'(b);
    length    = (AW+1)'(l);
    start     = 1'b1;
    st_cyc    = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chki("done_seen", int'(seen), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a[4];
    int exp_d[4];
    int dc, len, b;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // base 0, length 4, ready high: words 1..4 from 2 cycles after the start edge
    clear_logs(); ready_mode = 0;
    @(posedge clk); #1;
    do_start(0, 4);
    wait_done(50);
    chki("t1_count", acc_data.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_data", {1'b0, acc_data[k]}, (DW+1)'(k + 1));
      chki("t1_last", int'(acc_last[k]), int'(k == 3));
      chki("t1_cycle", acc_cyc[k], st_cyc + 3 + k);
    end
    chki("t1_done_cycle", done_cyc, st_cyc + 7);
    chki("t1_done_count", done_cnt, 1);

    // wrap from the top of the address space
    clear_logs();
    exp_a = '{2046, 2047, 0, 1};
    exp_d = '{2047, 2048, 1, 2};
    do_start(2046, 4);
    wait_done(50);
    chki("t2_re_count", re_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chki("t2_addr", re_log[k], exp_a[k]);
      chk("t2_data", {1'b0, acc_data[k]}, (DW+1)'(exp_d[k]));
    end

    // toggling ready
    clear_logs(); ready_mode = 1;
    do_start(0, 8);
    wait_done(100);
    chki("t3_count", acc_data.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("t3_data", {1'b0, acc_data[k]}, (DW+1)'(k + 1));
      chki("t3_last", int'(acc_last[k]), int'(k == 7));
    end

    // zero length: done in the cycle right after start is sampled
    clear_logs(); ready_mode = 0;
    do_start(0, 0);
    wait_done(10);
    chki("t4_no_re", re_log.size(), 0);
    chki("t4_no_words", acc_data.size(), 0);
    chki("t4_done_cycle", done_cyc, st_cyc + 1);
    chki("t4_done_count", done_cnt, 1);

    // reset in the middle of a burst, then a fresh burst
    clear_logs(); ready_mode = 0;
    do_start(0, 8);
    for (int i = 0; i < 60 && acc_data.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    chki("t5_three_words", acc_data.size(), 3);
    dc = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chki("t5_busy", int'(busy), 0);
    chki("t5_valid", int'(out_valid), 0);
    chki("t5_re", int'(re), 0);
    chki("t5_rd_addr", int'(rd_addr), 0);
    chk("t5_out_data", {out_last, out_data}, '0);
    @(posedge clk); #1;
    chki("t5_no_done", done_cnt, dc);
    clear_logs();
    do_start(100, 2);
    wait_done(50);
    chki("t5_count", acc_data.size(), 2);
    chk("t5_w0", {acc_last[0], acc_data[0]}, {1'b0, DW'(101)});
    chk("t5_w1", {acc_last[1], acc_data[1]}, {1'b1, DW'(102)});

    // start pulsed mid-burst is ignored
    clear_logs(); ready_mode = 1;
    do_start(10, 6);
    repeat (3) begin @(posedge clk); #1; end
    base_addr = AW'(500); length = (AW+1)'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    chki("t6_count", acc_data.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chki("t6_addr", re_log[k], 10 + k);
      chk("t6_data", {1'b0, acc_data[k]}, (DW+1)'(11 + k));
    end
    chki("t6_done_count", done_cnt, 1);

    // full-depth burst
    clear_logs(); ready_mode = 0;
    do_start(5, DEPTH);
    wait_done(DEPTH + 100);
    chki("t7_count", acc_data.size(), DEPTH);
    chk("t7_first", {1'b0, acc_data[0]}, (DW+1)'(6));
    chk("t7_final", {acc_last[DEPTH-1], acc_data[DEPTH-1]}, {1'b1, DW'(5)});

    // randomized bursts against the model
    for (int i = 0; i < DEPTH; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      clear_logs();
      ready_pct = $urandom_range(100, 20);
      len = $urandom_range(20, 0);
      b   = ($urandom_range(3) == 0) ? $urandom_range(DEPTH - 1, DEPTH - 12) : $urandom_range(DEPTH - 1);
      do_start(b, len);
      if (len > 0 && $urandom_range(1) == 1) begin
        base_addr = AW'($urandom); length = (AW+1)'($urandom_range(20, 1)); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_done(2000);
      chki("rnd_count", acc_data.size(), len);
      chki("rnd_done_count", done_cnt, 1);
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
